// File: rtl/text_screen_ctrl.sv
// Cursor-driven write controller for the text tile RAM, with a full-screen clear sweep.
// Optional cursor blink timebase from vsync when CURSOR_BLINK_EN is defined.
module text_screen_ctrl #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  ch_in,
    input  logic        ch_valid,
    output logic        ch_ready,
    input  logic        clr_req,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [6:0]  wr_data,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy,
    input  logic        vsync,
    output logic        cursor_on
);

    typedef enum logic {IDLE, CLEAR} state_e;

    localparam logic [6:0] XMAX  = 7'(COLS - 1);
    localparam logic [4:0] YMAX  = 5'(ROWS - 1);
    localparam logic [6:0] SPACE = 7'h20;

    state_e      state_q;
    logic        wr_en_q;
    logic [11:0] wr_addr_q;
    logic [6:0]  wr_data_q;
    logic [6:0]  x_q, sc_q;
    logic [4:0]  y_q, sr_q;
    logic        busy_q;

    logic       accept, printable, go_clear, clear_done;
    logic [6:0] x_d;
    logic [4:0] y_d;

    assign ch_ready   = (state_q == IDLE) & ~clr_req;
    assign accept     = ch_valid & ch_ready;
    assign printable  = (ch_in >= 7'h20) && (ch_in <= 7'h7E);
    assign go_clear   = clr_req | (accept && ch_in == 7'h0C);
    assign clear_done = (state_q == CLEAR) && sr_q == YMAX && sc_q == XMAX;

    assign x_d = (x_q == XMAX) ? 7'd0 : x_q + 7'd1;
    assign y_d = (y_q == YMAX) ? 5'd0 : y_q + 5'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            sc_q      <= '0;
            sr_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (go_clear) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        sc_q    <= '0;
                        sr_q    <= '0;
                    end else if (accept) begin
                        unique case (1'b1)
                            printable: begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= {y_q, x_q};
                                wr_data_q <= ch_in;
                                x_q       <= x_d;
                                if (x_q == XMAX) y_q <= y_d;
                            end
                            (ch_in == 7'h0D): x_q <= '0;
                            (ch_in == 7'h0A): y_q <= y_d;
                            (ch_in == 7'h08): begin
                                if (x_q != 7'd0) begin
                                    x_q       <= x_q - 7'd1;
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= {y_q, x_q - 7'd1};
                                    wr_data_q <= SPACE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= {sr_q, sc_q};
                    wr_data_q <= SPACE;
                    if (sc_q == XMAX) begin
                        sc_q <= '0;
                        sr_q <= sr_q + 5'd1;
                    end else begin
                        sc_q <= sc_q + 7'd1;
                    end
                    // Last write issued: hand back to IDLE with the cursor homed
                    if (clear_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        x_q     <= '0;
                        y_q     <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cur_x   = x_q;
    assign cur_y   = y_q;
    assign busy    = busy_q;

`ifdef CURSOR_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] cnt_q;
    logic          vs_q;
    logic          on_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            vs_q  <= 1'b1;
            on_q  <= 1'b0;
        end else begin
            vs_q <= vsync;
            if (accept || clear_done) begin
                cnt_q <= '0;
                on_q  <= 1'b1;
            end else if (vs_q && !vsync) begin
                if (cnt_q == BW'(BLINK_FRAMES - 1)) begin
                    cnt_q <= '0;
                    on_q  <= ~on_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign cursor_on = on_q;
`else
    logic unused_vsync;
    assign unused_vsync = vsync | (BLINK_FRAMES < 1);
    assign cursor_on    = 1'b0;
`endif

endmodule

// File: tb/tb_text_screen_ctrl.sv
// Directed bench for text_screen_ctrl: vector table for char handling,
// hand sequences for wrap, clear sweep, reset abort and cursor blink.
module tb_text_screen_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  ch_in = '0;
    logic        ch_valid = 1'b0;
    logic        ch_ready;
    logic        clr_req = 1'b0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [6:0]  wr_data;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;
    logic        vsync = 1'b1;
    logic        cursor_on;

    int n_cmp = 0;
    int n_bad = 0;

    text_screen_ctrl #(.COLS(80), .ROWS(30), .BLINK_FRAMES(4)) dut (
        .clk(clk), .rst(rst),
        .ch_in(ch_in), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .clr_req(clr_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy),
        .vsync(vsync), .cursor_on(cursor_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [6:0]  ch;
        logic        wen;
        logic [11:0] addr;
        logic [6:0]  data;
        logic [6:0]  x;
        logic [4:0]  y;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] c);
        ch_in    = c;
        ch_valid = 1'b1;
        tick();
        ch_valid = 1'b0;
    endtask

    task automatic vpulse();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int wcnt, bcnt, r, c;
        logic [11:0] last_a;
        bit bad_seq, done;

        tbl[0]  = '{1'b1, 7'h41, 1'b1, 12'h000, 7'h41, 7'd1, 5'd0};
        tbl[1]  = '{1'b1, 7'h42, 1'b1, 12'h001, 7'h42, 7'd2, 5'd0};
        tbl[2]  = '{1'b0, 7'h43, 1'b0, 12'h001, 7'h42, 7'd2, 5'd0};
        tbl[3]  = '{1'b1, 7'h0D, 1'b0, 12'h001, 7'h42, 7'd0, 5'd0};
        tbl[4]  = '{1'b1, 7'h0A, 1'b0, 12'h001, 7'h42, 7'd0, 5'd1};
        tbl[5]  = '{1'b1, 7'h08, 1'b0, 12'h001, 7'h42, 7'd0, 5'd1};
        tbl[6]  = '{1'b1, 7'h78, 1'b1, 12'h080, 7'h78, 7'd1, 5'd1};
        tbl[7]  = '{1'b1, 7'h08, 1'b1, 12'h080, 7'h20, 7'd0, 5'd1};
        tbl[8]  = '{1'b1, 7'h01, 1'b0, 12'h080, 7'h20, 7'd0, 5'd1};
        tbl[9]  = '{1'b1, 7'h7E, 1'b1, 12'h080, 7'h7E, 7'd1, 5'd1};
        tbl[10] = '{1'b1, 7'h7F, 1'b0, 12'h080, 7'h7E, 7'd1, 5'd1};
        tbl[11] = '{1'b1, 7'h0A, 1'b0, 12'h080, 7'h7E, 7'd1, 5'd2};

        // Reset state
        tick();
        tick();
        chk("rst_wen", wr_en, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_x", cur_x, 0);
        chk("rst_y", cur_y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur", cursor_on, 0);
        #3 rst = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            ch_in    = tbl[i].ch;
            ch_valid = tbl[i].v;
            #1;
            chk($sformatf("v%0d_rdy", i), ch_ready, 1);
            tick();
            chk($sformatf("v%0d_wen", i), wr_en, tbl[i].wen);
            chk($sformatf("v%0d_addr", i), wr_addr, tbl[i].addr);
            chk($sformatf("v%0d_data", i), wr_data, tbl[i].data);
            chk($sformatf("v%0d_x", i), cur_x, tbl[i].x);
            chk($sformatf("v%0d_y", i), cur_y, tbl[i].y);
        end
        ch_valid = 1'b0;

        // Bottom-right corner wrap to (0,0)
        send(7'h0D);
        for (int i = 0; i < 79; i++) send(7'h61);
        for (int i = 0; i < 27; i++) send(7'h0A);
        chk("corner_x", cur_x, 79);
        chk("corner_y", cur_y, 29);
        send(7'h5A);
        chk("z_wen", wr_en, 1);
        chk("z_addr", wr_addr, 12'hECF);
        chk("z_data", wr_data, 7'h5A);
        chk("z_x", cur_x, 0);
        chk("z_y", cur_y, 0);
        for (int i = 0; i < 29; i++) send(7'h0A);
        chk("lf29_y", cur_y, 29);
        send(7'h0A);
        chk("lfwrap_y", cur_y, 0);

        // CR/LF/BS from (5,3)
        for (int i = 0; i < 5; i++) send(7'h62);
        for (int i = 0; i < 3; i++) send(7'h0A);
        send(7'h0D);
        chk("cr_x", cur_x, 0);
        chk("cr_wen", wr_en, 0);
        send(7'h0A);
        chk("lf_y", cur_y, 4);
        send(7'h08);
        chk("bs0_x", cur_x, 0);
        chk("bs0_wen", wr_en, 0);
        send(7'h78);
        chk("x_addr", wr_addr, 12'h200);
        chk("x_data", wr_data, 7'h78);
        send(7'h08);
        chk("bs_wen", wr_en, 1);
        chk("bs_addr", wr_addr, 12'h200);
        chk("bs_data", wr_data, 7'h20);
        chk("bs_x", cur_x, 0);
        chk("bs_y", cur_y, 4);
        send(7'h63);

        // Clear sweep with a simultaneous char that must be refused
        ch_in    = 7'h51;
        ch_valid = 1'b1;
        clr_req  = 1'b1;
        #1;
        chk("clr_rdy", ch_ready, 0);
        tick();
        clr_req  = 1'b0;
        ch_valid = 1'b0;
        wcnt = 0; bcnt = 0; r = 0; c = 0;
        bad_seq = 1'b0; done = 1'b0; last_a = '0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (busy) bcnt++;
            if (wr_en) begin
                if (wr_addr != {5'(r), 7'(c)} || wr_data != 7'h20)
                    bad_seq = 1'b1;
                last_a = wr_addr;
                wcnt++;
                if (c == 79) begin
                    c = 0;
                    r++;
                end else begin
                    c++;
                end
            end
            if (i == 50) clr_req = 1'b1;
            if (i == 51) clr_req = 1'b0;
            if (i == 60) chk("busy_rdy", ch_ready, 0);
            if (i == 60) chk("busy_x", cur_x, 1);
            if (i > 0 && !busy && !wr_en) done = 1'b1;
            else tick();
        end
        chk("clr_done", done, 1);
        chk("clr_writes", wcnt, 2400);
        chk("clr_busy", bcnt, 2400);
        chk("clr_seq", bad_seq, 0);
        chk("clr_last", last_a, 12'hECF);
        chk("clr_x", cur_x, 0);
        chk("clr_y", cur_y, 0);
        send(7'h64);
        chk("post_addr", wr_addr, 12'h000);
        chk("post_data", wr_data, 7'h64);

        // FF starts a clear; reset aborts it after 100 writes
        send(7'h0C);
        chk("ff_busy", busy, 1);
        wcnt = 0;
        for (int i = 0; i < 200 && wcnt < 100; i++) begin
            tick();
            if (wr_en) wcnt++;
        end
        chk("ff_writes", wcnt, 100);
        #2 rst = 1'b0;
        #1;
        chk("arst_wen", wr_en, 0);
        chk("arst_addr", wr_addr, 0);
        chk("arst_data", wr_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_x", cur_x, 0);
        chk("arst_y", cur_y, 0);
        #3 rst = 1'b1;
        wcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wr_en) wcnt++;
        end
        chk("norestart", wcnt, 0);
        chk("norestart_busy", busy, 0);
        chk("idle_rdy", ch_ready, 1);

        // Cursor blink, BLINK_FRAMES=4
`ifdef CURSOR_BLINK_EN
        chk("blink0", cursor_on, 0);
        for (int i = 0; i < 4; i++) vpulse();
        chk("blink4", cursor_on, 1);
        for (int i = 0; i < 4; i++) vpulse();
        chk("blink8", cursor_on, 0);
        vpulse();
        vpulse();
        send(7'h65);
        chk("blink_force", cursor_on, 1);
        for (int i = 0; i < 3; i++) vpulse();
        chk("blink_hold", cursor_on, 1);
        vpulse();
        chk("blink_off", cursor_on, 0);
`else
        for (int i = 0; i < 8; i++) vpulse();
        chk("noblink", cursor_on, 0);
        send(7'h65);
        chk("noblink_char", cursor_on, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
